// File: rtl/inert_ctrl.sv
// rtl/inert_ctrl.sv - iNEMO sensor sequencer: power-on wait, configuration, yaw-rate reads
module inert_ctrl #(
    parameter int          INIT_W = 16,
    parameter logic [15:0] CFG0   = 16'h0D02,
    parameter logic [15:0] CFG1   = 16'h1160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        rdy,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    localparam logic [2:0] PWR     = 3'd0;
    localparam logic [2:0] CFG0_ST = 3'd1;
    localparam logic [2:0] CFG1_ST = 3'd2;
    localparam logic [2:0] IDLE    = 3'd3;
    localparam logic [2:0] RDL     = 3'd4;
    localparam logic [2:0] RDH     = 3'd5;
    localparam logic [2:0] VLD     = 3'd6;

    localparam logic [15:0] RD_YAW_LO = 16'hA600;
    localparam logic [15:0] RD_YAW_HI = 16'hA700;

    logic [2:0]        state;
    logic [INIT_W-1:0] cnt;
    logic              int_meta;
    logic              int_s;
    logic [7:0]        yaw_lo;

    // Only the low byte of a read carries data.
    logic rd_hi_unused;
    assign rd_hi_unused = ^rd_data[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PWR;
            cnt    <= '0;
            wrt    <= 1'b0;
            cmd    <= 16'h0000;
            rdy    <= 1'b0;
            yaw_lo <= 8'h00;
            yaw_rt <= 16'h0000;
            vld    <= 1'b0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                PWR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= CFG0_ST;
                        wrt   <= 1'b1;
                        cmd   <= CFG0;
                    end
                end
                CFG0_ST: begin
                    if (done) begin
                        state <= CFG1_ST;
                        wrt   <= 1'b1;
                        cmd   <= CFG1;
                    end
                end
                CFG1_ST: begin
                    if (done) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end
                end
                IDLE: begin
                    // Level-sensitive: INT still high on return here starts another read.
                    if (int_s) begin
                        state <= RDL;
                        wrt   <= 1'b1;
                        cmd   <= RD_YAW_LO;
                    end
                end
                RDL: begin
                    if (done) begin
                        yaw_lo <= rd_data[7:0];
                        state  <= RDH;
                        wrt    <= 1'b1;
                        cmd    <= RD_YAW_HI;
                    end
                end
                RDH: begin
                    if (done) begin
                        yaw_rt <= {rd_data[7:0], yaw_lo};
                        state  <= VLD;
                    end
                end
                VLD: begin
                    vld   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_ctrl.sv
// tb/tb_inert_ctrl.sv - scoreboard bench for inert_ctrl
module tb_inert_ctrl;

    localparam int TB_INIT_W = 8;
    localparam int WAIT_CLKS = 1 << TB_INIT_W;

    localparam int EV_WRT = 0;
    localparam int EV_VLD = 1;
    localparam int EV_RDY = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          at;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        rdy;
    logic [15:0] yaw_rt;
    logic        vld;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    evt_t        exp_q[$];
    logic        rdy_q = 1'b0;
    logic [15:0] last_yaw = 16'h0000;
    int          r;

    inert_ctrl #(.INIT_W(TB_INIT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .INT    (INT),
        .done   (done),
        .rd_data(rd_data),
        .wrt    (wrt),
        .cmd    (cmd),
        .rdy    (rdy),
        .yaw_rt (yaw_rt),
        .vld    (vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int kind);
        case (kind)
            EV_WRT:  return "wrt";
            EV_VLD:  return "vld";
            default: return "rdy";
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] data, input int at);
        evt_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input int kind, input logic [15:0] data);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got data %h at cycle %0d, expected no event", ev_name(kind), data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.at != cyc) begin
                failures++;
                $display("FAIL event_%s: got %s data %h at cycle %0d, expected %s data %h at cycle %0d",
                         ev_name(e.kind), ev_name(kind), data, cyc, ev_name(e.kind), e.data, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (wrt === 1'b1) check_evt(EV_WRT, cmd);
        if (vld === 1'b1) check_evt(EV_VLD, yaw_rt);
        if (rdy === 1'b1 && rdy_q !== 1'b1) check_evt(EV_RDY, 16'h0001);
        rdy_q = rdy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic pulse_done(input logic [15:0] d);
        rd_data = d;
        done    = 1'b1;
        tick(1);
        done    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wrt"}, {15'd0, wrt}, 16'h0000);
        chk({tag, "_cmd"}, cmd, 16'h0000);
        chk({tag, "_rdy"}, {15'd0, rdy}, 16'h0000);
        chk({tag, "_yaw"}, yaw_rt, 16'h0000);
        chk({tag, "_vld"}, {15'd0, vld}, 16'h0000);
    endtask

    task automatic start_read();
        INT = 1'b1;
        push(EV_WRT, 16'hA600, cyc + 3);
        tick(3);
    endtask

    // Entered in the cycle the 0x26 read wrt is visible.
    task automatic finish_read(input logic [7:0] lo, input logic [7:0] hi, input bit keep_int);
        tick(4);
        push(EV_WRT, 16'hA700, cyc + 1);
        pulse_done({8'hAB, lo});
        if (!keep_int) INT = 1'b0;
        tick(4);
        chk("yaw_held", yaw_rt, last_yaw);
        push(EV_VLD, {hi, lo}, cyc + 2);
        if (keep_int) push(EV_WRT, 16'hA600, cyc + 3);
        pulse_done({8'hCD, hi});
        tick(1);
        last_yaw = {hi, lo};
    endtask

    initial begin
        rst     = 1'b1;
        INT     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        tick(3);
        chk_reset_outputs("reset");

        rst = 1'b0;
        r   = cyc;
        push(EV_WRT, 16'h0D02, r + WAIT_CLKS);
        tick(7);
        pulse_done(16'h5555);
        tick_to(r + WAIT_CLKS);

        tick(40);
        push(EV_WRT, 16'h1160, cyc + 1);
        pulse_done(16'h0000);
        tick(39);
        push(EV_RDY, 16'h0001, cyc + 1);
        pulse_done(16'h0000);
        chk("rdy_after_cfg", {15'd0, rdy}, 16'h0001);

        tick(20);
        pulse_done(16'h00FF);
        tick(10);

        start_read();
        finish_read(8'h34, 8'h12, 1'b0);
        chk("yaw_1234", yaw_rt, 16'h1234);
        tick(10);

        start_read();
        finish_read(8'hF0, 8'hFF, 1'b0);
        chk("yaw_neg", yaw_rt, 16'hFFF0);
        tick(5);

        start_read();
        finish_read(8'h78, 8'h56, 1'b1);
        tick(1);
        finish_read(8'h01, 8'h80, 1'b0);
        chk("yaw_back_to_back", yaw_rt, 16'h8001);
        tick(10);

        start_read();
        tick(4);
        push(EV_WRT, 16'hA700, cyc + 1);
        pulse_done(16'h009A);
        INT = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk_reset_outputs("midreset");
        rst = 1'b0;
        r   = cyc;
        push(EV_WRT, 16'h0D02, r + WAIT_CLKS);
        tick(5);
        pulse_done(16'h00BC);
        tick_to(r + WAIT_CLKS);
        tick(5);
        chk("cmd_held", cmd, 16'h0D02);
        chk("rdy_after_midreset", {15'd0, rdy}, 16'h0000);
        chk("yaw_after_midreset", yaw_rt, 16'h0000);
        tick(5);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d outstanding, expected 0 (next %s data %h at cycle %0d)",
                     exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].data, exp_q[0].at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
